// File: rtl/rv_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op codes, FSM states, default width.
package rv_mdu_pkg;

    localparam int MD_XLEN = 32;

    localparam logic [3:0] MD_MUL    = 4'b0000;
    localparam logic [3:0] MD_MULH   = 4'b0001;
    localparam logic [3:0] MD_MULHSU = 4'b0010;
    localparam logic [3:0] MD_MULHU  = 4'b0011;
    localparam logic [3:0] MD_DIV    = 4'b0100;
    localparam logic [3:0] MD_DIVU   = 4'b0101;
    localparam logic [3:0] MD_REM    = 4'b0110;
    localparam logic [3:0] MD_REMU   = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step or restoring-divide step.
// The accumulator holds {high, low}; the low half is the multiplier or the dividend/quotient.
module muldiv_step
    import rv_mdu_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic                div_mode,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     opnd,
    output logic [2*XLEN-1:0]   acc_next
);

    logic [XLEN-1:0] mcand;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;

    always_comb begin
        mcand  = acc[0] ? opnd : {XLEN{1'b0}};
        sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mcand};
        rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff   = rem_sh - {1'b0, opnd};
        if (div_mode) begin
            // A clear sign bit on the trial subtract means the divisor fits: keep it, quotient bit 1.
            if (!diff[XLEN]) begin
                acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next = {sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer: FSM, iteration counter, sign fix-up and fast-case results.
// Optional FAST_MUL_EN: MUL* ops complete in one cycle on a full-width multiplier.
module muldiv_ctrl
    import rv_mdu_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [3:0]      i_ctrl,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_flush,
    output logic            o_ready,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    md_state_t         state_reg, state_next;
    logic [2*XLEN-1:0] acc_reg, acc_next;
    logic [XLEN-1:0]   opnd_reg, result_reg;
    logic              neg_reg;
    logic [2:0]        op_reg;
    logic [CW-1:0]     cnt_reg;

    logic            accept, fast, is_div, rem_op, a_signed, b_signed, a_neg, b_neg;
    logic            div_zero, div_ovf, neg_in;
    logic [XLEN-1:0] a_mag, b_mag, fast_res, sel_div, div_fix, calc_res;
    logic [2*XLEN-1:0] prod_fix;
`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] a_ext, b_ext, fast_prod;
`endif

    always_comb begin
        is_div   = i_ctrl[2];
        rem_op   = i_ctrl[1];
        a_signed = (i_ctrl == MD_MUL) || (i_ctrl == MD_MULH) || (i_ctrl == MD_MULHSU) ||
                   (i_ctrl == MD_DIV) || (i_ctrl == MD_REM);
        b_signed = (i_ctrl == MD_MUL) || (i_ctrl == MD_MULH) ||
                   (i_ctrl == MD_DIV) || (i_ctrl == MD_REM);
        a_neg    = a_signed && i_a[XLEN-1];
        b_neg    = b_signed && i_b[XLEN-1];
        a_mag    = a_neg ? -i_a : i_a;
        b_mag    = b_neg ? -i_b : i_b;
        // Remainder takes the dividend's sign; products and quotients take the XOR.
        neg_in   = (is_div && rem_op) ? a_neg : (a_neg ^ b_neg);
        div_zero = !i_ctrl[3] && is_div && (i_b == '0);
        div_ovf  = !i_ctrl[3] && is_div && b_signed &&
                   (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_b == '1);
        fast     = i_ctrl[3] || div_zero || div_ovf;
        fast_res = '0;
        if (div_zero) begin
            fast_res = rem_op ? i_a : '1;
        end else if (div_ovf) begin
            fast_res = rem_op ? '0 : i_a;
        end
`ifdef FAST_MUL_EN
        a_ext     = a_signed ? {{XLEN{i_a[XLEN-1]}}, i_a} : {{XLEN{1'b0}}, i_a};
        b_ext     = b_signed ? {{XLEN{i_b[XLEN-1]}}, i_b} : {{XLEN{1'b0}}, i_b};
        fast_prod = a_ext * b_ext;
        if (!i_ctrl[3] && !is_div) begin
            fast     = 1'b1;
            fast_res = (i_ctrl[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
        end
`endif
        accept = i_valid && (state_reg == ST_IDLE) && !i_flush;
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .div_mode (op_reg[2]),
        .acc      (acc_reg),
        .opnd     (opnd_reg),
        .acc_next (acc_next)
    );

    always_comb begin
        prod_fix = neg_reg ? -acc_next : acc_next;
        sel_div  = op_reg[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
        div_fix  = neg_reg ? -sel_div : sel_div;
        if (op_reg[2]) begin
            calc_res = div_fix;
        end else if (op_reg[1:0] == 2'b00) begin
            calc_res = prod_fix[XLEN-1:0];
        end else begin
            calc_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = fast ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (i_flush) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ready  = (state_reg == ST_IDLE);
        o_busy   = (state_reg == ST_CALC) || (state_reg == ST_DONE);
        o_valid  = (state_reg == ST_DONE) && !i_flush;
        o_result = result_reg;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_reg    <= '0;
            opnd_reg   <= '0;
            result_reg <= '0;
            neg_reg    <= 1'b0;
            op_reg     <= '0;
            cnt_reg    <= '0;
        end else if (accept) begin
            op_reg   <= i_ctrl[2:0];
            acc_reg  <= {{XLEN{1'b0}}, a_mag};
            opnd_reg <= b_mag;
            neg_reg  <= neg_in;
            cnt_reg  <= '0;
            if (fast) begin
                result_reg <= fast_res;
            end
        end else if (state_reg == ST_CALC) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + CW'(1);
            // Sign fix-up lands in the result register on the edge that enters DONE.
            if ((cnt_reg == LAST) && !i_flush) begin
                result_reg <= calc_res;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, corner sequences, randomized ops.
module tb_muldiv_ctrl;

`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [3:0]  i_ctrl = 4'h0;
    logic [31:0] i_a = 32'h0;
    logic [31:0] i_b = 32'h0;
    logic        i_flush = 1'b0;
    logic        o_ready, o_busy, o_valid;
    logic [31:0] o_result;

    int checks = 0;
    int errors = 0;

    muldiv_ctrl dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .i_ctrl   (i_ctrl),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_flush  (i_flush),
        .o_ready  (o_ready),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_result (o_result)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Architectural result computed with 64-bit arithmetic straight from the RV32M rules.
    function automatic logic [31:0] ref_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, p;
        logic [63:0] pu;
        logic        ovf;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ref_res = 32'h0;
        case (c)
            4'd0: begin p = sa * sb; ref_res = p[31:0]; end
            4'd1: begin p = sa * sb; ref_res = p[63:32]; end
            4'd2: begin p = sa * longint'({32'h0, b}); ref_res = p[63:32]; end
            4'd3: begin pu = {32'h0, a} * {32'h0, b}; ref_res = pu[63:32]; end
            4'd4: begin
                if (b == 0) ref_res = 32'hFFFF_FFFF;
                else if (ovf) ref_res = 32'h8000_0000;
                else begin p = sa / sb; ref_res = p[31:0]; end
            end
            4'd5: ref_res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd6: begin
                if (b == 0) ref_res = a;
                else if (ovf) ref_res = 32'h0;
                else begin p = sa % sb; ref_res = p[31:0]; end
            end
            4'd7: ref_res = (b == 0) ? a : a % b;
            default: ref_res = 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        if (c[3]) return 1;
        if (!c[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!c[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string nm, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input int el);
        int cyc;
        bit got;
        @(negedge i_clk);
        check({nm, "_ready"}, {31'h0, o_ready}, 32'h1);
        i_valid = 1'b1;
        i_ctrl  = c;
        i_a     = a;
        i_b     = b;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (cyc < 100 && !got) begin
            @(negedge i_clk);
            cyc++;
            if (cyc == 1) check({nm, "_busy"}, {31'h0, o_busy}, 32'h1);
            if (o_valid) got = 1'b1;
        end
        check({nm, "_lat"}, cyc, el);
        check({nm, "_res"}, o_result, er);
        $display("op %s ctrl=%h a=%h b=%h result=%h lat=%0d", nm, c, a, b, o_result, cyc);
        @(negedge i_clk);
        check({nm, "_pulse"}, {31'h0, o_valid}, 32'h0);
        check({nm, "_idle"}, {31'h0, o_ready}, 32'h1);
    endtask

    task automatic watch_no_valid(input string nm, input int n);
        int pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            if (o_valid) pulses++;
        end
        check(nm, pulses, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_gaps;
        int cyc;
        logic [3:0]  c;
        logic [31:0] a, b;

        vecs[0]  = '{4'h0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
        vecs[1]  = '{4'h1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT};
        vecs[2]  = '{4'h3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
        vecs[3]  = '{4'h2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT};
        vecs[4]  = '{4'h4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{4'h6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{4'h5, 32'd100,        32'd7,         32'd14,        33};
        vecs[7]  = '{4'h7, 32'd100,        32'd7,         32'd2,         33};
        vecs[8]  = '{4'h4, 32'd1234,       32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{4'h6, 32'd1234,       32'd0,         32'd1234,      1};
        vecs[10] = '{4'h5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[11] = '{4'h7, 32'd5,          32'd0,         32'd5,         1};
        vecs[12] = '{4'h4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[13] = '{4'h6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[14] = '{4'hA, 32'h1234_5678,  32'h9ABC_DEF0, 32'h0000_0000, 1};
        vecs[15] = '{4'h5, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[16] = '{4'h7, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33};
        vecs[17] = '{4'h1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT};
        vecs[18] = '{4'h0, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, MUL_LAT};
        vecs[19] = '{4'h4, 32'd1000,       32'hFFFF_FFFD, 32'hFFFF_FEB3, 33};

        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_ready",  {31'h0, o_ready}, 32'h1);
        check("rst_busy",   {31'h0, o_busy},  32'h0);
        check("rst_valid",  {31'h0, o_valid}, 32'h0);
        check("rst_result", o_result,         32'h0);

        for (int i = 0; i < 20; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
        end

        // Flush while a divide is ten iterations in.
        @(negedge i_clk);
        i_valid = 1'b1; i_ctrl = 4'h4; i_a = 32'd1000; i_b = 32'd3;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        repeat (10) @(negedge i_clk);
        i_flush = 1'b1;
        @(posedge i_clk);
        #1 i_flush = 1'b0;
        @(negedge i_clk);
        check("flush_ready", {31'h0, o_ready}, 32'h1);
        check("flush_busy",  {31'h0, o_busy},  32'h0);
        check("flush_valid", {31'h0, o_valid}, 32'h0);
        watch_no_valid("flush_no_pulse", 40);
        run_op("after_flush", 4'h4, 32'd1000, 32'd3, 32'd333, 33);

        // Flush and request in the same IDLE cycle: nothing is taken.
        @(negedge i_clk);
        i_valid = 1'b1; i_flush = 1'b1; i_ctrl = 4'h5; i_a = 32'd9; i_b = 32'd0;
        @(posedge i_clk);
        #1 begin i_valid = 1'b0; i_flush = 1'b0; end
        @(negedge i_clk);
        check("idle_flush_ready", {31'h0, o_ready}, 32'h1);
        check("idle_flush_busy",  {31'h0, o_busy},  32'h0);

        // Flush during DONE of a fast op suppresses the pulse.
        @(negedge i_clk);
        i_valid = 1'b1; i_ctrl = 4'h4; i_a = 32'd9; i_b = 32'd0;
        @(posedge i_clk);
        #1 begin i_valid = 1'b0; i_flush = 1'b1; end
        @(negedge i_clk);
        check("done_flush_valid", {31'h0, o_valid}, 32'h0);
        check("done_flush_busy",  {31'h0, o_busy},  32'h1);
        @(posedge i_clk);
        #1 i_flush = 1'b0;
        @(negedge i_clk);
        check("done_flush_ready", {31'h0, o_ready}, 32'h1);

        // Reset in the middle of CALC.
        @(negedge i_clk);
        i_valid = 1'b1; i_ctrl = 4'h7; i_a = 32'd12345; i_b = 32'd77;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        repeat (5) @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check("mrst_ready",  {31'h0, o_ready}, 32'h1);
        check("mrst_busy",   {31'h0, o_busy},  32'h0);
        check("mrst_valid",  {31'h0, o_valid}, 32'h0);
        check("mrst_result", o_result,         32'h0);
        watch_no_valid("mrst_no_pulse", 40);
        run_op("after_rst", 4'h7, 32'd12345, 32'd77, 32'd25, 33);

        // Request held high across the busy window: one op only until ready returns.
        @(negedge i_clk);
        i_valid = 1'b1; i_ctrl = 4'h5; i_a = 32'd100; i_b = 32'd7;
        @(posedge i_clk);
        busy_gaps = 0;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge i_clk);
            cyc++;
            if (!o_busy) busy_gaps++;
            if (o_valid) break;
        end
        check("hold_lat", cyc, 33);
        check("hold_busy", busy_gaps, 0);
        check("hold_res", o_result, 32'd14);
        @(negedge i_clk);
        check("hold_ready", {31'h0, o_ready}, 32'h1);
        i_valid = 1'b0;
        @(negedge i_clk);
        check("hold_idle", {31'h0, o_busy}, 32'h0);
        $display("op hold ctrl=5 a=00000064 b=00000007 result=%h lat=%0d", o_result, cyc);

        for (int i = 0; i < 60; i++) begin
            c = ($urandom_range(0, 9) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
            a = rand_opnd();
            b = rand_opnd();
            if ($urandom_range(0, 15) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            run_op($sformatf("rnd%0d", i), c, a, b, ref_res(c, a, b), ref_lat(c, a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
